// File: rtl/spgd_accum_pkg.sv
// Shared SPGD definitions: Q-format defaults, clamp magnitude and the
// accumulator FSM state encoding.
package spgd_accum_pkg;

    localparam int unsigned DATA_WIDTH_D = 32;
    localparam int unsigned INT_WIDTH_D  = 16;
    localparam int unsigned N_CH_D       = 4;
    // Clamp magnitude in integer units (+/-8.0 in the default 16Q16 format).
    localparam int unsigned CLAMP_MAG    = 8;

    localparam logic [31:0] U_MAX_D = 32'h0008_0000;
    localparam logic [31:0] U_MIN_D = 32'hFFF8_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/spgd_sat_add.sv
// Saturating signed add: one extra bit of headroom so the sum never wraps,
// then clamp to [U_MIN, U_MAX] and flag when the clamp engaged.
module spgd_sat_add
    import spgd_accum_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_D,
    parameter logic [DATA_WIDTH-1:0] U_MAX      = DATA_WIDTH'(U_MAX_D),
    parameter logic [DATA_WIDTH-1:0] U_MIN      = DATA_WIDTH'(U_MIN_D)
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y_c,
    output logic                  clamped_c
);

    localparam int unsigned SUM_W = DATA_WIDTH + 1;

    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] max_c;
    logic signed [SUM_W-1:0] min_c;

    always_comb begin
        sum_c     = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
        max_c     = $signed({U_MAX[DATA_WIDTH-1], U_MAX});
        min_c     = $signed({U_MIN[DATA_WIDTH-1], U_MIN});
        y_c       = sum_c[DATA_WIDTH-1:0];
        clamped_c = 1'b0;
        if (sum_c > max_c) begin
            y_c       = U_MAX;
            clamped_c = 1'b1;
        end else if (sum_c < min_c) begin
            y_c       = U_MIN;
            clamped_c = 1'b1;
        end
    end

endmodule

// File: rtl/spgd_accum.sv
// Per-channel SPGD control-vector accumulator: two-stage read/add/clamp/write
// pipeline with same-channel bypass, sticky saturation flags and a clear sweep.
module spgd_accum
    import spgd_accum_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_D,
    parameter int unsigned           INT_WIDTH  = INT_WIDTH_D,
    parameter int unsigned           N_CH       = N_CH_D,
    parameter int unsigned           CH_W       = $clog2(N_CH),
    parameter logic [DATA_WIDTH-1:0] U_MAX      = DATA_WIDTH'(CLAMP_MAG) << (DATA_WIDTH - INT_WIDTH),
    parameter logic [DATA_WIDTH-1:0] U_MIN      = DATA_WIDTH'(0) - U_MAX,
    parameter logic [DATA_WIDTH-1:0] U_INIT     = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic [CH_W-1:0]            s_ch,
    input  logic                       clear,
    output logic [N_CH*DATA_WIDTH-1:0] u_flat,
    output logic [N_CH-1:0]            sat,
    output logic                       out_valid,
    output logic [CH_W-1:0]            out_ch
);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       cnt_q, cnt_d;
    logic                  sweep_wr_c;

    logic [DATA_WIDTH-1:0] u_q [N_CH];

    logic                  s1_valid_q;
    logic [CH_W-1:0]       s1_ch_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s2_valid_q;
    logic [CH_W-1:0]       s2_ch_q;
    logic [DATA_WIDTH-1:0] s2_res_q;
    logic                  s2_clamp_q;

    logic                  in_range_c;
    logic                  accept_c;
    logic                  upd_wr_c;
    logic [DATA_WIDTH-1:0] rd_c;
    logic [DATA_WIDTH-1:0] sum_res_c;
    logic                  sum_clamp_c;

    assign s_ready = (state_q == ST_RUN) && !clear;

    // Out-of-range channel indices are only possible when N_CH is not a power of two.
    if (N_CH == (1 << CH_W)) begin : g_ch_full
        assign in_range_c = 1'b1;
    end else begin : g_ch_part
        assign in_range_c = (32'(s_ch) < N_CH);
    end

    assign accept_c = s_valid && s_ready && in_range_c;
    assign upd_wr_c = s2_valid_q && !clear;

    // Bypass the stage-2 result so back-to-back steps to one channel accumulate.
    assign rd_c = (s2_valid_q && (s2_ch_q == s1_ch_q)) ? s2_res_q : u_q[s1_ch_q];

    spgd_sat_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .U_MAX      (U_MAX),
        .U_MIN      (U_MIN)
    ) u_sat_add (
        .a         (rd_c),
        .b         (s1_data_q),
        .y_c       (sum_res_c),
        .clamped_c (sum_clamp_c)
    );

    always_ff @(posedge clk or negedge rstn) begin : p_state
        if (!rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin : p_next
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_wr_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                sweep_wr_c = 1'b1;
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == CH_W'(N_CH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CH_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A clear kills both stages in the same cycle it is seen.
    always_ff @(posedge clk or negedge rstn) begin : p_pipe
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_res_q   <= '0;
            s2_clamp_q <= 1'b0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_ch_q   <= s_ch;
                s1_data_q <= s_data;
            end
            s2_valid_q <= s1_valid_q && !clear;
            s2_ch_q    <= s1_ch_q;
            s2_res_q   <= sum_res_c;
            s2_clamp_q <= sum_clamp_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : p_bank
        if (!rstn) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                u_q[k] <= U_INIT;
            end
            sat       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
        end else begin
            out_valid <= upd_wr_c;
            if (upd_wr_c) begin
                u_q[s2_ch_q] <= s2_res_q;
                out_ch       <= s2_ch_q;
                if (s2_clamp_q) begin
                    sat[s2_ch_q] <= 1'b1;
                end
            end
            if (sweep_wr_c) begin
                u_q[cnt_q] <= U_INIT;
                sat[cnt_q] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_flat
        assign u_flat[k*DATA_WIDTH +: DATA_WIDTH] = u_q[k];
    end

endmodule

// File: tb/tb_spgd_accum.sv
// Bench for spgd_accum: directed scenarios plus random traffic, checked every
// cycle against a sequential-update reference model.
module tb_spgd_accum;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 4;
    localparam longint UMAX_L = 64'sd524288;
    localparam longint UMIN_L = -64'sd524288;

    logic              clk = 1'b0;
    logic              rstn;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [1:0]        s_ch;
    logic              clear;
    logic [NC*DW-1:0]  u_flat;
    logic [NC-1:0]     sat;
    logic              out_valid;
    logic [1:0]        out_ch;

    always #5 clk = ~clk;

    spgd_accum dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_ch      (s_ch),
        .clear     (clear),
        .u_flat    (u_flat),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ch    (out_ch)
    );

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] data;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_u [NC];
    logic [3:0]  m_sat;
    logic        m_ov;
    logic [1:0]  m_och;
    bit          m_clearing;
    int          m_pos;
    int          cyc = 0;
    pend_t       pq [$];
    logic        last_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                              output bit clamped);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        clamped = 1'b0;
        if (s > UMAX_L) begin
            s = UMAX_L;
            clamped = 1'b1;
        end else if (s < UMIN_L) begin
            s = UMIN_L;
            clamped = 1'b1;
        end
        return 32'(s);
    endfunction

    function automatic logic [31:0] u_of(input int k);
        return u_flat[k*32 +: 32];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_u[k] = '0;
        m_sat      = '0;
        m_ov       = 1'b0;
        m_och      = '0;
        m_clearing = 1'b0;
        m_pos      = 0;
        pq.delete();
    endtask

    // Steps take effect two edges after acceptance, in acceptance order.
    task automatic model_edge();
        pend_t p;
        bit    cl;
        cyc++;
        m_ov = 1'b0;
        if (m_clearing) begin
            m_u[m_pos]   = '0;
            m_sat[m_pos] = 1'b0;
            if (clear) m_pos = 0;
            else if (m_pos == NC - 1) begin
                m_clearing = 1'b0;
                m_pos = 0;
            end else m_pos++;
        end else if (clear) begin
            pq.delete();
            m_clearing = 1'b1;
            m_pos = 0;
        end else begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                m_u[p.ch] = model_add(m_u[p.ch], p.data, cl);
                if (cl) m_sat[p.ch] = 1'b1;
                m_ov  = 1'b1;
                m_och = 2'(p.ch);
            end
            if (s_valid) pq.push_back('{cyc + 2, int'(s_ch), s_data});
        end
    endtask

    task automatic check_outputs();
        logic [127:0] exp_u;
        for (int k = 0; k < NC; k++) exp_u[k*32 +: 32] = m_u[k];
        chk("u_flat", u_flat, exp_u);
        chk("sat", 128'(sat), 128'(m_sat));
        chk("out_valid", 128'(out_valid), 128'(m_ov));
        chk("out_ch", 128'(out_ch), 128'(m_och));
    endtask

    task automatic tick();
        #1;
        last_ready = s_ready;
        chk("s_ready", 128'(s_ready), 128'(!m_clearing && !clear));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [31:0] d, input logic clr);
        s_valid = v;
        s_ch    = ch;
        s_data  = d;
        clear   = clr;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic check_reset_state();
        chk("rst_u", u_flat, 128'h0);
        chk("rst_sat", 128'(sat), 128'h0);
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_out_ch", 128'(out_ch), 128'h0);
    endtask

    initial begin
        int          pulses;
        int          lowcnt;
        int          r;
        logic [31:0] d;

        rstn = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        #2 rstn = 1'b1;
        #1 chk("rst_ready", 128'(s_ready), 128'h1);
        idle(1);

        // Single step to channel 1.
        drive(1'b1, 2'd1, 32'h0001_8000, 1'b0);
        tick();
        idle(1);
        chk("single_lat1", 128'(out_valid), 128'h0);
        tick();
        chk("single_ov", 128'(out_valid), 128'h1);
        chk("single_ch", 128'(out_ch), 128'h1);
        chk("single_u1", 128'(u_of(1)), 128'h0001_8000);
        chk("single_u0", 128'(u_of(0)), 128'h0);

        // Back-to-back steps to channel 2 go through the bypass.
        pulses = 0;
        repeat (3) begin
            drive(1'b1, 2'd2, 32'h0001_0000, 1'b0);
            tick();
            pulses += int'(out_valid);
        end
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        repeat (3) begin
            tick();
            pulses += int'(out_valid);
        end
        chk("burst_pulses", 128'(pulses), 128'd3);
        chk("burst_u2", 128'(u_of(2)), 128'h0003_0000);

        // Saturation on channel 0, flag stays set after coming off the rail.
        drive(1'b1, 2'd0, 32'h0007_0000, 1'b0);
        tick();
        drive(1'b1, 2'd0, 32'h0002_0000, 1'b0);
        tick();
        idle(2);
        chk("sat_u0", 128'(u_of(0)), 128'h0008_0000);
        chk("sat_bit0", 128'(sat[0]), 128'h1);
        drive(1'b1, 2'd0, 32'hFFFF_0000, 1'b0);
        tick();
        idle(2);
        chk("unsat_u0", 128'(u_of(0)), 128'h0007_0000);
        chk("sticky_bit0", 128'(sat[0]), 128'h1);

        // Extreme steps at the rail must not wrap.
        drive(1'b1, 2'd3, 32'h0008_0000, 1'b0);
        tick();
        idle(2);
        chk("rail_u3", 128'(u_of(3)), 128'h0008_0000);
        chk("rail_nosat3", 128'(sat[3]), 128'h0);
        drive(1'b1, 2'd3, 32'h7FFF_FFFF, 1'b0);
        tick();
        idle(2);
        chk("nowrap_pos_u3", 128'(u_of(3)), 128'h0008_0000);
        drive(1'b1, 2'd3, 32'h8000_0000, 1'b0);
        tick();
        idle(2);
        chk("nowrap_neg_u3", 128'(u_of(3)), 128'hFFF8_0000);
        chk("nowrap_sat3", 128'(sat[3]), 128'h1);

        // Clear with two steps in flight: clear cycle plus four sweep cycles not ready.
        drive(1'b1, 2'd1, 32'h0000_8000, 1'b0);
        tick();
        drive(1'b1, 2'd2, 32'h0000_4000, 1'b0);
        tick();
        drive(1'b0, 2'd0, 32'h0, 1'b1);
        lowcnt = 0;
        tick();
        if (!last_ready) lowcnt++;
        clear = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (last_ready) break;
            lowcnt++;
        end
        chk("clear_low_cycles", 128'(lowcnt), 128'd5);
        chk("clear_u", u_flat, 128'h0);
        chk("clear_sat", 128'(sat), 128'h0);

        // Clear again mid-sweep: 3 cycles before the restart, then a full 4-cycle sweep.
        drive(1'b0, 2'd0, 32'h0, 1'b1);
        lowcnt = 0;
        tick();
        if (!last_ready) lowcnt++;
        drive(1'b1, 2'd0, 32'h0001_0000, 1'b0);
        tick();
        if (!last_ready) lowcnt++;
        clear = 1'b1;
        tick();
        if (!last_ready) lowcnt++;
        clear = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (last_ready) break;
            lowcnt++;
        end
        chk("reclear_low_cycles", 128'(lowcnt), 128'd7);
        idle(3);
        chk("reclear_u0", 128'(u_of(0)), 128'h0001_0000);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) d = 32'h7FFF_FFFF;
            else if (r == 1) d = 32'h8000_0000;
            else if (r < 4) d = $urandom();
            else d = 32'($urandom_range(0, 32'h0006_0000)) - 32'h0003_0000;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d,
                  $urandom_range(0, 59) == 0);
            tick();
        end
        idle(4);

        // Asynchronous reset in the middle of traffic.
        drive(1'b1, 2'd1, 32'h0000_4000, 1'b0);
        tick();
        tick();
        #2 rstn = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        check_reset_state();
        chk("rst2_ready", 128'(s_ready), 128'h1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spgd_accum.md
# spgd_accum

Per-channel control-vector accumulator for the SPGD loop. It sits directly downstream of the fixed-point multiplier that forms the scaled gradient step (gain × ΔJ × δu). Each accepted product is added to the addressed channel's actuator value, with saturation to a programmable range. It holds the vector that drives the actuator outputs.

## Interface
- DATA_WIDTH, 32: word size; signed two's complement, same Q format as the multiplier output.
- INT_WIDTH, 16: integer bits including sign; fraction bits = DATA_WIDTH−INT_WIDTH.
- N_CH, 4: number of channels, ≥2.
- CH_W, $clog2(N_CH): channel index width.
- U_MAX, 32'h0008_0000: upper clamp (+8.0 in 16Q16).
- U_MIN, 32'hFFF8_0000: lower clamp (−8.0).
- U_INIT, 0: value loaded at reset and on clear.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  1  step word valid.
- s_ready  out  1  block can accept a step.
- s_data  in  DATA_WIDTH  signed step (multiplier product).
- s_ch  in  CH_W  target channel.
- clear  in  1  single-cycle request to reload all channels with U_INIT.
- u_flat  out  N_CH*DATA_WIDTH  registered channel values; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- sat  out  N_CH  sticky per-channel saturation flags.
- out_valid  out  1  one-cycle pulse when a channel is written by an update.
- out_ch  out  CH_W  channel written when out_valid is high.

## Operation
- FSM states: RUN and CLEAR. Reset state is RUN.
- s_ready = (state==RUN) && !clear, combinational. A step is accepted when s_valid && s_ready. s_ch ≥ N_CH is accepted and discarded (no write, no out_valid).
- Stage 1 (cycle after accept):
  - Read the channel value, bypassing from the stage-2 result if stage 2 is writing the same channel.
  - Form sum = sign-extended acc + sign-extended s_data at DATA_WIDTH+1 bits, so the sum cannot wrap.
- Stage 2:
  - Clamp the sum: if sum > U_MAX, result = U_MAX; if sum < U_MIN, result = U_MIN.
  - Write the result to the channel and set sat[ch] if clamped.
  - Pulse out_valid and drive out_ch.
- sat bits are sticky. Only reset or clear reset them.
- clear, when high in RUN:
  - Both pipeline stages are invalidated the same cycle; in-flight steps never write and never pulse out_valid.
  - Next state is CLEAR with sweep counter = 0.
- CLEAR: one channel per cycle is written with U_INIT and its sat bit cleared, counter increments. After channel N_CH−1 the state returns to RUN.
- clear while in CLEAR restarts the sweep at counter 0.
- Reset (asynchronous, any time):
  - All channels = U_INIT, sat = 0.
  - out_valid = 0, out_ch = 0.
  - Pipeline valids = 0, state = RUN, counter = 0.
  - s_ready is 1 after reset release, since it is combinational.

## Timing
- Latency: a step accepted at edge T gives out_valid and the updated u_flat at edge T+2.
- Throughput: one step per cycle, any channel order. Back-to-back steps to the same channel accumulate exactly through the bypass, with no stall.
- Clear: s_ready is low in the clear cycle plus N_CH CLEAR cycles. u_flat channel k shows U_INIT from edge clear+1+k+1.
- out_valid never asserts in CLEAR.

## Structure
- Shared SPGD package: Q-format constants (INT_WIDTH, DATA_WIDTH, clamp defaults) and the FSM state encoding.
- One natural sub-module: spgd_sat_add. It is combinational: DATA_WIDTH+1-bit add, clamp against U_MIN/U_MAX, and a clamped flag output. It is reusable by other SPGD stages.
- The register bank, bypass and FSM stay in spgd_accum.

## Test plan
All cases use default parameters.
- Reset: hold rstn low mid-stream, then release → all u = 0, sat = 4'b0000, out_valid = 0, s_ready = 1.
- Single step: ch1, 32'h0001_8000 (+1.5) → two cycles later out_valid = 1, out_ch = 1, u1 = 32'h0001_8000; other channels unchanged.
- Same-channel burst: ch2, +1.0 in three consecutive cycles → u2 = 32'h0003_0000; three out_valid pulses.
- Saturation: ch0, +7.0 then +2.0 → u0 = 32'h0008_0000, sat[0] = 1. Then −1.0 → u0 = 32'h0007_0000, sat[0] stays 1.
- No-wrap corner: with u3 = U_MAX, apply step 32'h7FFF_FFFF → u3 = 32'h0008_0000, not negative. Then apply 32'h8000_0000 → u3 = 32'hFFF8_0000.
- Clear mid-stream: assert clear while two steps are in flight → neither writes, s_ready low for 5 cycles, all u = 0 and sat = 0 afterwards. A second clear during the sweep extends it to a full N_CH cycles from restart.
